udp_tx_framer: RTL and testbench

//  Upstream source for one udp_arbitr_3 input port (tx_*2 or tx_*3).

---
 rtl/udp_tx_framer.sv | 218 +++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// Ethernet/IPv4/UDP transmit framer: fixed header fields plus a show-ahead payload FIFO,
// streamed to an arbiter port as big-endian 32-bit words and padded to the 60-byte minimum.
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC  = 48'h0007ED000001,
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [31:0] SRC_IP   = 32'hC0A80001,
    parameter logic [31:0] DST_IP   = 32'hC0A800FF,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [10:0] MAX_LEN  = 11'd1472,
    parameter int unsigned IFG_CYC  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [10:0] pay_len,
    input  logic [31:0] pay_data,
    input  logic        pay_empty,
    output logic        pay_rd,
    output logic        en_udp,
    input  logic        tx_rdy,
    output logic        tx_wren,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [1:0]  tx_mod,
    output logic [31:0] tx_data,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RDY = 3'd2,
        HDR      = 3'd3,
        PAY      = 3'd4,
        PAD      = 3'd5,
        GAP      = 3'd6
    } state_t;

    localparam logic [9:0]  HDR_WORDS = 10'd10;
    localparam logic [11:0] MIN_BYTES = 12'd60;
    localparam logic [7:0]  GAP_LAST  = 8'(IFG_CYC - 1);

    state_t      state_r, state_s;
    logic [10:0] len_r;
    logic [15:0] ident_r, csum_r, plow_r;
    logic [9:0]  last_idx_r, npop_r, wcnt_r;
    logic [1:0]  mod_r;
    logic [7:0]  gap_r;
    logic        under_r;

    logic        pay_rd_r, en_udp_r, tx_wren_r, tx_sop_r, tx_eop_r, busy_r, err_r;
    logic [1:0]  tx_mod_r;
    logic [31:0] tx_data_r;

    logic        emit_s, last_s, pop_due_s, pop_next_s, accept_s, reject_s;
    logic [9:0]  idx_s, nxt_idx_s;
    logic [11:0] blen_s;
    logic [31:0] cur_s, word_s;
    logic        pay_rd_s, en_udp_s, tx_wren_s, tx_sop_s, tx_eop_s, busy_s, err_s;
    logic [1:0]  tx_mod_s;
    logic [31:0] tx_data_s;

    function automatic logic [15:0] ip_csum(input logic [10:0] len, input logic [15:0] id);
        logic [19:0] sum;
        sum = 20'h04500 + {9'd0, len} + 20'd28 + {4'd0, id} + 20'h04000 + {4'd0, TTL, 8'h11}
            + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
            + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
        sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
        sum = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
        return ~sum[15:0];
    endfunction

    assign accept_s  = (state_r == IDLE) && start && (pay_len <= MAX_LEN);
    assign reject_s  = (state_r == IDLE) && start && (pay_len > MAX_LEN);
    assign blen_s    = (({1'b0, len_r} + 12'd42) < MIN_BYTES) ? MIN_BYTES : ({1'b0, len_r} + 12'd42);
    assign last_s    = (idx_s == last_idx_r);
    assign nxt_idx_s = idx_s + 10'd1;
    assign pop_due_s = (idx_s >= HDR_WORDS) && ((idx_s - HDR_WORDS) < npop_r);
    // pay_rd is registered, so it is raised one word early and the pop lands on the edge that consumes the head
    assign pop_next_s = emit_s && !last_s && (nxt_idx_s >= HDR_WORDS) && ((nxt_idx_s - HDR_WORDS) < npop_r);

    // Word-slot decode: word 0 goes out on the grant edge, later words on every following edge
    always_comb begin
        emit_s = 1'b0;
        idx_s  = wcnt_r;
        case (state_r)
            WAIT_RDY: begin
                emit_s = tx_rdy;
                idx_s  = 10'd0;
            end
            HDR, PAY, PAD: emit_s = 1'b1;
            default:       emit_s = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = REQ;
                else          state_s = IDLE;
            end
            REQ: state_s = WAIT_RDY;
            WAIT_RDY, HDR, PAY, PAD: begin
                if (!emit_s)                             state_s = state_r;
                else if (last_s)                         state_s = GAP;
                else if (nxt_idx_s < HDR_WORDS)          state_s = HDR;
                else if (nxt_idx_s <= HDR_WORDS + npop_r) state_s = PAY;
                else                                     state_s = PAD;
            end
            GAP: begin
                if (gap_r == GAP_LAST) state_s = IDLE;
                else                   state_s = GAP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Frame word mux and next values of the registered outputs
    always_comb begin
        if (pop_due_s && !pay_empty) cur_s = pay_data;
        else                         cur_s = 32'd0;
        case (idx_s)
            10'd0:   word_s = DST_MAC[47:16];
            10'd1:   word_s = {DST_MAC[15:0], SRC_MAC[47:32]};
            10'd2:   word_s = SRC_MAC[31:0];
            10'd3:   word_s = {16'h0800, 16'h4500};
            10'd4:   word_s = {{5'd0, len_r} + 16'd28, ident_r};
            10'd5:   word_s = {16'h4000, TTL, 8'h11};
            10'd6:   word_s = {csum_r, SRC_IP[31:16]};
            10'd7:   word_s = {SRC_IP[15:0], DST_IP[31:16]};
            10'd8:   word_s = {DST_IP[15:0], SRC_PORT};
            10'd9:   word_s = {DST_PORT, {5'd0, len_r} + 16'd8};
            default: word_s = {(idx_s == HDR_WORDS) ? 16'h0000 : plow_r, cur_s[31:16]};
        endcase
        tx_wren_s = emit_s;
        tx_sop_s  = emit_s && (idx_s == 10'd0);
        tx_eop_s  = emit_s && last_s;
        if (emit_s && last_s) tx_mod_s = mod_r;
        else                  tx_mod_s = 2'd0;
        if (emit_s) tx_data_s = word_s;
        else        tx_data_s = 32'd0;
        pay_rd_s = pop_next_s;
        en_udp_s = accept_s;
        busy_s   = (state_s != IDLE);
        err_s    = reject_s || (emit_s && pop_due_s && pay_empty && !under_r);
    end

    // State, frame context and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            len_r      <= 11'd0;
            ident_r    <= 16'd0;
            csum_r     <= 16'd0;
            plow_r     <= 16'd0;
            last_idx_r <= 10'd0;
            npop_r     <= 10'd0;
            wcnt_r     <= 10'd0;
            mod_r      <= 2'd0;
            gap_r      <= 8'd0;
            under_r    <= 1'b0;
            pay_rd_r   <= 1'b0;
            en_udp_r   <= 1'b0;
            tx_wren_r  <= 1'b0;
            tx_sop_r   <= 1'b0;
            tx_eop_r   <= 1'b0;
            tx_mod_r   <= 2'd0;
            tx_data_r  <= 32'd0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            pay_rd_r  <= pay_rd_s;
            en_udp_r  <= en_udp_s;
            tx_wren_r <= tx_wren_s;
            tx_sop_r  <= tx_sop_s;
            tx_eop_r  <= tx_eop_s;
            tx_mod_r  <= tx_mod_s;
            tx_data_r <= tx_data_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
            if (accept_s) len_r <= pay_len;
            if (state_r == REQ) begin
                csum_r     <= ip_csum(len_r, ident_r);
                last_idx_r <= 10'((blen_s + 12'd3) >> 2) - 10'd1;
                npop_r     <= 10'(({1'b0, len_r} + 12'd3) >> 2);
                mod_r      <= 2'd0 - blen_s[1:0];
                wcnt_r     <= 10'd0;
                plow_r     <= 16'd0;
                under_r    <= 1'b0;
            end
            if (emit_s) begin
                wcnt_r <= nxt_idx_s;
                if (idx_s >= HDR_WORDS) plow_r <= cur_s[15:0];
                if (pop_due_s && pay_empty) under_r <= 1'b1;
                if (last_s) ident_r <= ident_r + 16'd1;
            end
            if (state_r == GAP) gap_r <= gap_r + 8'd1;
            else                gap_r <= 8'd0;
        end
    end

    assign pay_rd  = pay_rd_r;
    assign en_udp  = en_udp_r;
    assign tx_wren = tx_wren_r;
    assign tx_sop  = tx_sop_r;
    assign tx_eop  = tx_eop_r;
    assign tx_mod  = tx_mod_r;
    assign tx_data = tx_data_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Scoreboard bench for udp_tx_framer: a byte-level frame model queues the expected words,
// a monitor compares every word the DUT presents.
module tb_udp_tx_framer;

    localparam logic [47:0] SRC_MAC = 48'h0007ED000001;
    localparam logic [47:0] DST_MAC = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] SRC_IP  = 32'hC0A80001;
    localparam logic [31:0] DST_IP  = 32'hC0A800FF;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] pay_len = 11'd0;
    logic [31:0] pay_data = 32'd0;
    logic        pay_empty = 1'b1;
    logic        tx_rdy = 1'b0;
    logic        pay_rd, en_udp, tx_wren, tx_sop, tx_eop, busy, err;
    logic [1:0]  tx_mod;
    logic [31:0] tx_data;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] fifo_q[$];
    logic [31:0] pay_words[$];
    logic [7:0]  fb[$];
    int          checks = 0, errors = 0, en_cnt = 0, err_cnt = 0, pop_cnt = 0, word_no = 0;
    bit          in_frame = 1'b0;
    logic [15:0] ident_m = 16'd0;

    udp_tx_framer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pay_len(pay_len),
        .pay_data(pay_data), .pay_empty(pay_empty), .pay_rd(pay_rd), .en_udp(en_udp),
        .tx_rdy(tx_rdy), .tx_wren(tx_wren), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_mod(tx_mod), .tx_data(tx_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic put(input logic [63:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) fb.push_back(v[8*k +: 8]);
    endtask

    // Reference: lay the frame out byte by byte, then cut it into big-endian words
    task automatic push_frame(input int len, input int nw, input logic [15:0] id);
        int          bl, nwd, np;
        logic [31:0] s;
        exp_t        e;
        bl  = (42 + len > 60) ? 42 + len : 60;
        nwd = (bl + 3) / 4;
        np  = (len + 3) / 4;
        fb.delete();
        put(64'(DST_MAC), 6); put(64'(SRC_MAC), 6); put(64'h0800, 2); put(64'h4500, 2);
        put(64'(len + 28), 2); put(64'(id), 2); put(64'h4000, 2); put(64'h4011, 2); put(64'h0, 2);
        put(64'(SRC_IP), 4); put(64'(DST_IP), 4); put(64'd5000, 2); put(64'd5001, 2);
        put(64'(len + 8), 2); put(64'h0, 2);
        s = 32'd0;
        for (int k = 14; k < 34; k += 2) s = s + {16'd0, fb[k], fb[k + 1]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        fb[24] = ~s[15:8];
        fb[25] = ~s[7:0];
        for (int j = 0; j < np; j++) put((j < nw) ? 64'(pay_words[j]) : 64'd0, 4);
        while (fb.size() < 4 * nwd) fb.push_back(8'h00);
        for (int i = 0; i < nwd; i++) begin
            e.d   = {fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]};
            e.sop = (i == 0);
            e.eop = (i == nwd - 1);
            e.mod = e.eop ? 2'((4 - bl % 4) % 4) : 2'd0;
            exp_q.push_back(e);
        end
    endtask

    // Show-ahead FIFO model: pops on the edge where pay_rd is high and data is present
    always @(posedge clk) begin
        if (pay_rd === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        #1;
        pay_empty = (fifo_q.size() == 0);
        pay_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    end

    // Monitor: compares each presented word and checks that a frame has no wren gaps
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            in_frame = 1'b0;
            word_no  = 0;
        end else begin
            if (en_udp === 1'b1) en_cnt++;
            if (err === 1'b1) err_cnt++;
            if (tx_wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {tx_data, tx_sop, tx_eop, tx_mod}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("word%0d", word_no), {tx_data, tx_sop, tx_eop, tx_mod}, mon_e);
                end
                word_no  = (tx_eop === 1'b1) ? 0 : word_no + 1;
                in_frame = (tx_eop !== 1'b1);
            end else if (in_frame) begin
                chk("wren_gap", tx_wren, 1);
                in_frame = 1'b0;
            end
        end
    end

    task automatic run_frame(input int len, input int nw, input int d, input bit mid, input bit fixed);
        int          np, t, e0, n0, p0;
        logic [31:0] w;
        np = (len + 3) / 4;
        pay_words.delete();
        for (int j = 0; j < nw; j++) begin
            w = (fixed && j == 0) ? 32'hA1B2C3D4 : $urandom;
            pay_words.push_back(w);
            fifo_q.push_back(w);
        end
        push_frame(len, nw, ident_m);
        e0 = err_cnt; n0 = en_cnt; p0 = pop_cnt;
        @(negedge clk); start = 1'b1; pay_len = 11'(len);
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        t = 0;
        while (en_udp !== 1'b1 && t < 8) begin @(negedge clk); t++; end
        chk("en_udp_seen", en_udp, 1);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            chk("no_wren_before_rdy", tx_wren, 0);
        end
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        chk("sop_latency", {tx_wren, tx_sop}, 2'b11);
        tx_rdy = 1'b0;
        if (mid) begin
            repeat (3) @(negedge clk);
            start = 1'b1; pay_len = 11'd5;
            @(negedge clk); start = 1'b0;
        end
        t = 0;
        while (busy === 1'b1 && t < 3000) begin @(negedge clk); t++; end
        chk("busy_released", busy, 0);
        chk("en_udp_pulses", 64'(en_cnt - n0), 64'd1);
        chk("err_pulses", 64'(err_cnt - e0), (nw < np) ? 64'd1 : 64'd0);
        chk("pops", 64'(pop_cnt - p0), 64'((nw < np) ? nw : np));
        chk("all_words_seen", 64'(exp_q.size()), 64'd0);
        ident_m = ident_m + 16'd1;
        fifo_q.delete();
    endtask

    initial begin
        int e0, n0, lr;
        repeat (3) @(negedge clk);
        chk("reset_wren", tx_wren, 0);
        chk("reset_busy", busy, 0);
        chk("reset_en_udp", en_udp, 0);
        chk("reset_err_pay_rd", {err, pay_rd}, 0);
        chk("reset_data_flags", {tx_data, tx_sop, tx_eop, tx_mod}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(4, 1, 2, 1'b0, 1'b1);
        run_frame(1472, 368, 1, 1'b0, 1'b0);
        run_frame(19, 5, 3, 1'b0, 1'b0);
        run_frame(30, 8, 20, 1'b1, 1'b0);

        // Oversized payload is rejected without requesting the arbiter
        e0 = err_cnt; n0 = en_cnt;
        @(negedge clk); start = 1'b1; pay_len = 11'd1473;
        @(negedge clk); start = 1'b0;
        chk("reject_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("reject_err_pulse", 64'(err_cnt - e0), 64'd1);
        chk("reject_no_en_udp", 64'(en_cnt - n0), 64'd0);
        chk("reject_busy_later", busy, 0);

        run_frame(19, 2, 2, 1'b0, 1'b0);

        // Reset in the middle of a frame
        pay_words.delete();
        for (int j = 0; j < 25; j++) begin
            pay_words.push_back($urandom);
            fifo_q.push_back(pay_words[j]);
        end
        push_frame(100, 25, ident_m);
        @(negedge clk); start = 1'b1; pay_len = 11'd100;
        @(negedge clk); start = 1'b0;
        @(negedge clk); tx_rdy = 1'b1;
        @(negedge clk); tx_rdy = 1'b0;
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_frame_outputs",
            {tx_wren, tx_sop, tx_eop, tx_mod, tx_data, pay_rd, en_udp, busy, err}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        fifo_q.delete();
        ident_m = 16'd0;

        run_frame(10, 3, 1, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            lr = int'($urandom_range(0, 120));
            run_frame(lr, (lr + 3) / 4, int'($urandom_range(1, 6)), r[0], 1'b0);
        end
        run_frame(0, 0, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
